// File: rtl/cache_fill_ctrl_pkg.sv
// Shared cache definitions: bus widths, request kinds and fill-controller state encoding.
package cache_fill_ctrl_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LINE_BYTES = 4;

  localparam logic REQ_KIND_READ  = 1'b0;
  localparam logic REQ_KIND_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_THRU = 3'd1,
    ST_FILL       = 3'd2,
    ST_TAG_UPDATE = 3'd3,
    ST_DONE       = 3'd4
  } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Cache-side request, memory beat and fill/tag write signals of the fill controller.
interface cache_fill_ctrl_if
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = DEF_ADDR_W,
  parameter int DATA_BUS_WIDTH    = DEF_DATA_W
) ();

  logic                         req_valid;
  logic                         req_write;
  logic [ADDRESS_BUS_WIDTH-1:0] req_addr;
  logic [DATA_BUS_WIDTH-1:0]    req_wdata;
  logic                         stall;
  logic                         done;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_addr;
  logic [DATA_BUS_WIDTH-1:0]    mem_wdata;
  logic                         mem_ack;
  logic [DATA_BUS_WIDTH-1:0]    mem_rdata;
  logic                         fill_we;
  logic [ADDRESS_BUS_WIDTH-1:0] fill_addr;
  logic [DATA_BUS_WIDTH-1:0]    fill_data;
  logic                         tag_we;
  logic [ADDRESS_BUS_WIDTH-1:0] tag_addr;

  // The controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, done, mem_req, mem_we, mem_addr, mem_wdata,
    output fill_we, fill_addr, fill_data, tag_we, tag_addr
  );

  // The cache/memory environment side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, done, mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_we, fill_addr, fill_data, tag_we, tag_addr
  );

endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: single-byte write-through or a full line fill from memory,
// followed by a tag/valid write that only happens once every beat of the line has landed.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = DEF_ADDR_W,
  parameter int DATA_BUS_WIDTH    = DEF_DATA_W,
  parameter int LINE_BYTES        = DEF_LINE_BYTES
) (
  input logic               clock,
  input logic               reset,
  cache_fill_ctrl_if.slave  bus
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int BW = $clog2(LINE_BYTES);

  fill_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          fill_we_q, fill_we_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [DW-1:0] fill_data_q, fill_data_d;

  logic [AW-1:0] line_base;
  logic [AW-1:0] beat_addr;
  logic          last_beat;

  assign line_base = {addr_q[AW-1:BW], {BW{1'b0}}};
  assign beat_addr = {addr_q[AW-1:BW], beat_q};
  assign last_beat = (beat_q == BW'(LINE_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      beat_q      <= '0;
      fill_we_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      beat_q      <= beat_d;
      fill_we_q   <= fill_we_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    beat_d      = beat_q;
    fill_we_d   = 1'b0;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          beat_d  = '0;
          state_d = (bus.req_write == REQ_KIND_WRITE) ? ST_WRITE_THRU : ST_FILL;
        end
      end
      ST_WRITE_THRU: begin
        if (bus.mem_ack) state_d = ST_DONE;
      end
      ST_FILL: begin
        // The cache write lags the ack by one cycle, so the last one overlaps TAG_UPDATE.
        if (bus.mem_ack) begin
          fill_we_d   = 1'b1;
          fill_addr_d = beat_addr;
          fill_data_d = bus.mem_rdata;
          beat_d      = beat_q + BW'(1);
          if (last_beat) state_d = ST_TAG_UPDATE;
        end
      end
      ST_TAG_UPDATE: state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  logic          stall_c, done_c, mem_req_c, mem_we_c, tag_we_c;
  logic [AW-1:0] mem_addr_c, tag_addr_c;
  logic [DW-1:0] mem_wdata_c;

  always_comb begin
    stall_c     = 1'b0;
    done_c      = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    tag_we_c    = 1'b0;
    tag_addr_c  = '0;
    case (state_q)
      ST_WRITE_THRU: begin
        stall_c     = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = write_q;
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
      end
      ST_FILL: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_we_c   = write_q;
        mem_addr_c = beat_addr;
      end
      ST_TAG_UPDATE: begin
        stall_c    = 1'b1;
        tag_we_c   = 1'b1;
        tag_addr_c = line_base;
      end
      ST_DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.stall     = stall_c;
  assign bus.done      = done_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.fill_we   = fill_we_q;
  assign bus.fill_addr = fill_addr_q;
  assign bus.fill_data = fill_data_q;
  assign bus.tag_we    = tag_we_c;
  assign bus.tag_addr  = tag_addr_c;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed and randomized operations against a per-operation
// model of the expected beat addresses, fill writes, tag write and latency.
module tb_cache_fill_ctrl;
  import cache_fill_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cache_fill_ctrl_if #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();

  cache_fill_ctrl #(
    .ADDRESS_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH(DW),
    .LINE_BYTES(LB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit ack_pat[$];
  int pat_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 0: always ack, 1: random ack, 2: scripted pattern then ack
  function automatic bit next_ack(input int mode);
    bit a;
    if (mode == 0) a = 1'b1;
    else if (mode == 1) a = 1'($urandom_range(0, 1));
    else if (pat_idx < ack_pat.size()) begin
      a = ack_pat[pat_idx];
      pat_idx++;
    end else a = 1'b1;
    return a;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},     32'(bus.stall), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
    chk({tag, "_mem_req"},   32'(bus.mem_req), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_fill_we"},   32'(bus.fill_we), 0);
    chk({tag, "_fill_addr"}, 32'(bus.fill_addr), 0);
    chk({tag, "_fill_data"}, 32'(bus.fill_data), 0);
    chk({tag, "_tag_we"},    32'(bus.tag_we), 0);
    chk({tag, "_tag_addr"},  32'(bus.tag_addr), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int mode, input bit seq_rd, input bit spurious,
                        output int beats, output int we_cycles, output int lat);
    logic [AW-1:0] base;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    bit pend, fin, ack;
    int cyc;
    base = a & ~AW'(LB - 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.mem_ack   = 1'b0;
    @(negedge clock);
    bus.req_valid = spurious;
    bus.req_write = ~wr;
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    cyc = 1; beats = 0; we_cycles = 0; pend = 1'b0; fin = 1'b0; pa = '0; pd = '0;
    while (!fin && cyc < 200) begin
      chk("busy_done", 32'(bus.done), 0);
      if (pend) begin
        chk("fill_we", 32'(bus.fill_we), 1);
        chk("fill_addr", 32'(bus.fill_addr), 32'(pa));
        chk("fill_data", 32'(bus.fill_data), 32'(pd));
      end else chk("fill_we_idle", 32'(bus.fill_we), 0);
      pend = 1'b0;
      if (wr) begin
        chk("wt_mem_req", 32'(bus.mem_req), 1);
        chk("wt_mem_we", 32'(bus.mem_we), 1);
        chk("wt_mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("wt_mem_wdata", 32'(bus.mem_wdata), 32'(wd));
        chk("wt_stall", 32'(bus.stall), 1);
        chk("wt_tag_we", 32'(bus.tag_we), 0);
        we_cycles += int'(bus.mem_we);
        ack = next_ack(mode);
        bus.mem_ack   = ack;
        bus.mem_rdata = DW'($urandom);
        if (ack) fin = 1'b1;
      end else if (beats < LB) begin
        chk("rd_mem_req", 32'(bus.mem_req), 1);
        chk("rd_mem_we", 32'(bus.mem_we), 0);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'(AW'(base + AW'(beats))));
        chk("rd_stall", 32'(bus.stall), 1);
        chk("rd_tag_we", 32'(bus.tag_we), 0);
        ack = next_ack(mode);
        bus.mem_ack   = ack;
        bus.mem_rdata = seq_rd ? DW'(8'hA0 + beats) : DW'($urandom);
        if (ack) begin
          pend = 1'b1;
          pa   = AW'(base + AW'(beats));
          pd   = bus.mem_rdata;
          beats++;
        end
      end else begin
        chk("tag_we", 32'(bus.tag_we), 1);
        chk("tag_addr", 32'(bus.tag_addr), 32'(base));
        chk("tag_mem_req", 32'(bus.mem_req), 0);
        chk("tag_stall", 32'(bus.stall), 1);
        bus.mem_ack = 1'($urandom_range(0, 1));
        fin = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    chk("op_budget", 32'(fin), 1);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_stall", 32'(bus.stall), 0);
    chk("done_mem_req", 32'(bus.mem_req), 0);
    chk("done_tag_we", 32'(bus.tag_we), 0);
    chk("done_fill_we", 32'(bus.fill_we), 0);
    lat = cyc;
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    @(negedge clock);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_stall", 32'(bus.stall), 0);
    chk("idle_mem_req", 32'(bus.mem_req), 0);
  endtask

  initial begin
    int beats, wec, lat;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    pat_idx = 0;
    reset = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Line fill, memory always ready
    run_op(1'b0, 16'h1236, 8'h00, 0, 1'b1, 1'b0, beats, wec, lat);
    chk("fill_beats", 32'(beats), LB);
    chk("fill_latency", 32'(lat), LB + 2);

    // Write-through with three wait cycles
    ack_pat = '{1'b0, 1'b0, 1'b0, 1'b1}; pat_idx = 0;
    run_op(1'b1, 16'h00FF, 8'h5A, 2, 1'b0, 1'b0, beats, wec, lat);
    chk("wt_we_cycles", 32'(wec), 4);
    chk("wt_latency", 32'(lat), 5);

    // Write-through, memory always ready
    run_op(1'b1, 16'hBEEF, 8'hC3, 0, 1'b0, 1'b0, beats, wec, lat);
    chk("wt_fast_latency", 32'(lat), 2);

    // Wait-state pattern on a fill
    ack_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; pat_idx = 0;
    run_op(1'b0, 16'h4321, 8'h00, 2, 1'b0, 1'b0, beats, wec, lat);
    chk("ws_beats", 32'(beats), LB);
    chk("ws_pattern_used", 32'(pat_idx), 8);
    chk("ws_latency", 32'(lat), 10);

    // mem_ack while idle must not start anything
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_ack_mem_req", 32'(bus.mem_req), 0);
      chk("idle_ack_stall", 32'(bus.stall), 0);
      chk("idle_ack_fill_we", 32'(bus.fill_we), 0);
    end
    bus.mem_ack = 1'b0;

    // req_valid held throughout a fill
    run_op(1'b0, 16'h8005, 8'h00, 0, 1'b0, 1'b1, beats, wec, lat);
    chk("spur_beats", 32'(beats), LB);
    chk("spur_latency", 32'(lat), LB + 2);
    @(negedge clock);
    chk("spur_after_stall", 32'(bus.stall), 0);

    // Reset after two beats of a fill
    bus.req_valid = 1'b1;
    bus.req_write = REQ_KIND_READ;
    bus.req_addr  = 16'h2468;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h11;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_mem_addr", 32'(bus.mem_addr), 32'h246A);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    bus.mem_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_rst_tag_we", 32'(bus.tag_we), 0);
      chk("post_rst_mem_req", 32'(bus.mem_req), 0);
    end
    run_op(1'b0, 16'h2468, 8'h00, 0, 1'b1, 1'b0, beats, wec, lat);
    chk("post_rst_beats", 32'(beats), LB);

    // Randomized mix
    for (int i = 0; i < 24; i++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      run_op(wr, AW'($urandom), DW'($urandom), 1, 1'b0, 1'($urandom_range(0, 1)),
             beats, wec, lat);
      if (!wr) chk("rand_beats", 32'(beats), LB);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
